// File: rtl/fsm_semaforo_temporizado_pkg.sv
// Shared definitions for the timed traffic-light controller: state encoding
// and default phase durations.
package fsm_semaforo_temporizado_pkg;

   typedef enum logic [2:0] {
      S_GREEN     = 3'd0,
      S_YELLOW    = 3'd1,
      S_RED       = 3'd2,
      S_BLINK_ON  = 3'd3,
      S_BLINK_OFF = 3'd4
   } state_t;

   localparam int DEF_W         = 4;
   localparam int DEF_T_MIN_GRN = 8;
   localparam int DEF_T_YLW     = 3;
   localparam int DEF_T_RED     = 6;
   localparam int DEF_T_BLINK   = 2;

endpackage

// File: rtl/semaforo_timer.sv
// Phase down-counter: loads (duration-1) on state entry, decrements to 0 and
// holds there; expired flags the terminal count.
module semaforo_timer #(
   parameter int             W       = 4,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         res,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!res)
         cnt <= RST_VAL;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/fsm_semaforo_temporizado.sv
// Timed traffic-light controller with pedestrian latch and night blink mode.
//
// state       | meaning
// S_GREEN     | traffic go; held until min-green elapsed and a request exists
// S_YELLOW    | traffic clearing, T_YLW cycles
// S_RED       | traffic stop, pedestrians walk, T_RED cycles
// S_BLINK_ON  | night mode, yellow lit for T_BLINK cycles
// S_BLINK_OFF | night mode, all dark for T_BLINK cycles
module fsm_semaforo_temporizado
   import fsm_semaforo_temporizado_pkg::*;
#(
   parameter int W         = DEF_W,
   parameter int T_MIN_GRN = DEF_T_MIN_GRN,
   parameter int T_YLW     = DEF_T_YLW,
   parameter int T_RED     = DEF_T_RED,
   parameter int T_BLINK   = DEF_T_BLINK
) (
   input  logic clk,
   input  logic res,
   input  logic CAR,
   input  logic PED,
   input  logic NIGHT,
   output logic GRN,
   output logic YLW,
   output logic RED,
   output logic WALK
);

   localparam int T_MAX = (2 ** W) - 1;

   if (T_MIN_GRN < 1 || T_MIN_GRN > T_MAX) begin : g_bad_grn
      $error("T_MIN_GRN out of range for timer width W");
   end
   if (T_YLW < 1 || T_YLW > T_MAX) begin : g_bad_ylw
      $error("T_YLW out of range for timer width W");
   end
   if (T_RED < 1 || T_RED > T_MAX) begin : g_bad_red
      $error("T_RED out of range for timer width W");
   end
   if (T_BLINK < 1 || T_BLINK > T_MAX) begin : g_bad_blink
      $error("T_BLINK out of range for timer width W");
   end

   localparam logic [W-1:0] LD_GRN   = W'(T_MIN_GRN - 1);
   localparam logic [W-1:0] LD_YLW   = W'(T_YLW - 1);
   localparam logic [W-1:0] LD_RED   = W'(T_RED - 1);
   localparam logic [W-1:0] LD_BLINK = W'(T_BLINK - 1);

   state_t       state, state_n;
   logic         ped_lat;
   logic         expired;
   logic         load;
   logic [W-1:0] load_val;

   semaforo_timer #(
      .W       (W),
      .RST_VAL (LD_GRN)
   ) u_timer (
      .clk      (clk),
      .res      (res),
      .load     (load),
      .load_val (load_val),
      .expired  (expired)
   );

   always_ff @(posedge clk) begin
      if (!res)
         state <= S_GREEN;
      else
         state <= state_n;
   end

   // Entering red serves the pending pedestrian request, so clearing wins
   // over a press arriving on that same edge.
   always_ff @(posedge clk) begin
      if (!res)
         ped_lat <= 1'b0;
      else if (state_n == S_RED && state != S_RED)
         ped_lat <= 1'b0;
      else if (PED && state != S_RED)
         ped_lat <= 1'b1;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_GREEN:     if (expired && (CAR || ped_lat || NIGHT)) state_n = S_YELLOW;
         S_YELLOW:    if (expired) state_n = S_RED;
         S_RED:       if (expired) state_n = NIGHT ? S_BLINK_ON : S_GREEN;
         S_BLINK_ON:  if (!NIGHT) state_n = S_RED;
                      else if (expired) state_n = S_BLINK_OFF;
         S_BLINK_OFF: if (!NIGHT) state_n = S_RED;
                      else if (expired) state_n = S_BLINK_ON;
         default:     state_n = S_GREEN;
      endcase
   end

   always_comb begin
      load     = (state_n != state);
      load_val = LD_GRN;
      case (state_n)
         S_GREEN:     load_val = LD_GRN;
         S_YELLOW:    load_val = LD_YLW;
         S_RED:       load_val = LD_RED;
         S_BLINK_ON,
         S_BLINK_OFF: load_val = LD_BLINK;
         default:     load_val = LD_GRN;
      endcase
   end

   always_comb begin
      GRN  = 1'b0;
      YLW  = 1'b0;
      RED  = 1'b0;
      WALK = 1'b0;
      case (state)
         S_GREEN:    GRN = 1'b1;
         S_YELLOW:   YLW = 1'b1;
         S_RED:      begin
            RED  = 1'b1;
            WALK = 1'b1;
         end
         S_BLINK_ON: YLW = 1'b1;
         default:    ;
      endcase
   end

endmodule

// File: tb/tb_fsm_semaforo_temporizado.sv
// Directed bench for the timed traffic-light controller at default parameters.
module tb_fsm_semaforo_temporizado;

   logic clk = 1'b0;
   logic res, CAR, PED, NIGHT;
   logic GRN, YLW, RED, WALK;
   logic [3:0] lamps;
   int errors = 0;
   int checks = 0;

   localparam logic [3:0] L_GRN  = 4'b1000;
   localparam logic [3:0] L_YLW  = 4'b0100;
   localparam logic [3:0] L_RED  = 4'b0011;
   localparam logic [3:0] L_DARK = 4'b0000;

   fsm_semaforo_temporizado dut (
      .clk   (clk),
      .res   (res),
      .CAR   (CAR),
      .PED   (PED),
      .NIGHT (NIGHT),
      .GRN   (GRN),
      .YLW   (YLW),
      .RED   (RED),
      .WALK  (WALK)
   );

   always #5 clk = ~clk;

   assign lamps = {GRN, YLW, RED, WALK};

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Leaves the bench at observation 0: state has just been reset, res released.
   task automatic do_reset();
      res = 1'b0;
      tick();
      res = 1'b1;
   endtask

   task automatic test_reset();
      CAR = 1'b0; PED = 1'b0; NIGHT = 1'b0;
      do_reset();
      checks++;
      if (lamps !== L_GRN) begin
         errors++;
         $display("FAIL reset_lamps got=%b exp=%b", lamps, L_GRN);
      end
      checks++;
      if (dut.ped_lat !== 1'b0) begin
         errors++;
         $display("FAIL reset_ped_lat got=%b exp=0", dut.ped_lat);
      end
   endtask

   task automatic test_car_cycle();
      logic [3:0] exp;
      do_reset();
      CAR = 1'b1;
      for (int i = 0; i < 18; i++) begin
         exp = (i < 8) ? L_GRN : (i < 11) ? L_YLW : (i < 17) ? L_RED : L_GRN;
         checks++;
         if (lamps !== exp) begin
            errors++;
            $display("FAIL car_cycle obs=%0d got=%b exp=%b", i, lamps, exp);
         end
         tick();
      end
      CAR = 1'b0;
   endtask

   task automatic test_idle_hold();
      do_reset();
      for (int i = 0; i < 30; i++) begin
         checks++;
         if (lamps !== L_GRN) begin
            errors++;
            $display("FAIL idle_hold obs=%0d got=%b exp=%b", i, lamps, L_GRN);
         end
         tick();
      end
      CAR = 1'b1;
      tick();
      CAR = 1'b0;
      checks++;
      if (lamps !== L_YLW) begin
         errors++;
         $display("FAIL idle_car_pulse got=%b exp=%b", lamps, L_YLW);
      end
   endtask

   task automatic test_ped();
      logic [3:0] exp;
      do_reset();
      tick();
      PED = 1'b1;
      tick();
      PED = 1'b0;
      // obs 2 .. 10, holding PED high across the edge that enters red
      for (int i = 2; i < 11; i++) begin
         exp = (i < 8) ? L_GRN : L_YLW;
         checks++;
         if (lamps !== exp || dut.ped_lat !== 1'b1) begin
            errors++;
            $display("FAIL ped_wait obs=%0d got=%b/%b exp=%b/1", i, lamps, dut.ped_lat, exp);
         end
         if (i == 10) PED = 1'b1;
         tick();
      end
      PED = 1'b0;
      checks++;
      if (lamps !== L_RED || dut.ped_lat !== 1'b0) begin
         errors++;
         $display("FAIL ped_red_entry got=%b/%b exp=%b/0", lamps, dut.ped_lat, L_RED);
      end
      tick();
      PED = 1'b1;
      tick();
      PED = 1'b0;
      checks++;
      if (dut.ped_lat !== 1'b0) begin
         errors++;
         $display("FAIL ped_during_red got=%b exp=0", dut.ped_lat);
      end
      // obs 13; green from obs 17, expired at 24; no request pending so stays green
      for (int i = 13; i < 27; i++) tick();
      checks++;
      if (lamps !== L_GRN) begin
         errors++;
         $display("FAIL ped_red_ignored_hold got=%b exp=%b", lamps, L_GRN);
      end
   endtask

   task automatic test_night();
      logic [3:0] exp;
      do_reset();
      for (int i = 0; i < 8; i++) tick();
      NIGHT = 1'b1;
      tick();
      // obs 9 .. 22
      for (int i = 9; i < 23; i++) begin
         exp = (i < 12) ? L_YLW : (i < 18) ? L_RED :
               (i < 20) ? L_YLW : (i < 22) ? L_DARK : L_YLW;
         checks++;
         if (lamps !== exp) begin
            errors++;
            $display("FAIL night obs=%0d got=%b exp=%b", i, lamps, exp);
         end
         if (i == 22) NIGHT = 1'b0;
         tick();
      end
      // blink exited with timer not yet expired; full red follows
      for (int i = 23; i < 30; i++) begin
         exp = (i < 29) ? L_RED : L_GRN;
         checks++;
         if (lamps !== exp) begin
            errors++;
            $display("FAIL night_exit obs=%0d got=%b exp=%b", i, lamps, exp);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] exp;
      do_reset();
      NIGHT = 1'b1;
      PED = 1'b1;
      tick();
      PED = 1'b0;
      for (int i = 1; i < 9; i++) tick();
      checks++;
      if (lamps !== L_YLW || dut.ped_lat !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre got=%b/%b exp=%b/1", lamps, dut.ped_lat, L_YLW);
      end
      do_reset();
      checks++;
      if (lamps !== L_GRN || dut.ped_lat !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got=%b/%b exp=%b/0", lamps, dut.ped_lat, L_GRN);
      end
      for (int i = 1; i < 9; i++) begin
         tick();
         exp = (i < 8) ? L_GRN : L_YLW;
         checks++;
         if (lamps !== exp) begin
            errors++;
            $display("FAIL mid_min_green obs=%0d got=%b exp=%b", i, lamps, exp);
         end
      end
      NIGHT = 1'b0;
   endtask

   initial begin
      res = 1'b0; CAR = 1'b0; PED = 1'b0; NIGHT = 1'b0;
      @(negedge clk);
      test_reset();
      test_car_cycle();
      test_idle_hold();
      test_ped();
      test_night();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
